// File: rtl/memory_arbiter.sv
// Two-requester arbiter that shares one single-port memory bus between a CPU (0) and a loader (1).
// Tie-break is fixed priority to requester 0 unless ARBITER_ROUND_ROBIN_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; latches the winner's command
// ADDR  | address phase, write strobe asserted for writes
// WAIT  | read data phase, bus_data_out captured at the end
// ACK   | one-cycle completion pulse to the winner
module memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_0,
  input  logic                    req_1,
  input  logic                    write_0,
  input  logic                    write_1,
  input  logic [ADDR_WIDTH-1:0]   address_0,
  input  logic [ADDR_WIDTH-1:0]   address_1,
  input  logic [DATA_WIDTH-1:0]   data_in_0,
  input  logic [DATA_WIDTH-1:0]   data_in_1,
  input  logic [DATA_WIDTH/8-1:0] write_mask_0,
  input  logic [DATA_WIDTH/8-1:0] write_mask_1,
  output logic                    ack_0,
  output logic                    ack_1,
  output logic [DATA_WIDTH-1:0]   data_out_0,
  output logic [DATA_WIDTH-1:0]   data_out_1,
  output logic [ADDR_WIDTH-1:0]   bus_address,
  output logic [DATA_WIDTH-1:0]   bus_data_in,
  output logic [DATA_WIDTH/8-1:0] bus_write_mask,
  output logic                    bus_enable,
  output logic                    bus_write_enable,
  input  logic [DATA_WIDTH-1:0]   bus_data_out,
  output logic [1:0]              grant,
  output logic                    busy
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACK} state_t;

  state_t                state_q;
  logic [1:0]            grant_q;
  logic                  busy_q;
  logic [1:0]            ack_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] dout0_q;
  logic [DATA_WIDTH-1:0] dout1_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_din_q;
  logic [MW-1:0]         bus_mask_q;
  logic                  bus_en_q;
  logic                  bus_we_q;
  logic                  win1_d;
`ifdef ARBITER_ROUND_ROBIN_EN
  logic                  last_q;
`endif

`ifdef ARBITER_ROUND_ROBIN_EN
  always_comb begin
    win1_d = req_1;
    if (req_0 && req_1) win1_d = ~last_q;
  end
`else
  always_comb begin
    win1_d = req_1 && !req_0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      ack_q      <= 2'b00;
      write_q    <= 1'b0;
      dout0_q    <= '0;
      dout1_q    <= '0;
      bus_addr_q <= '0;
      bus_din_q  <= '0;
      bus_mask_q <= '0;
      bus_en_q   <= 1'b0;
      bus_we_q   <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_0 || req_1) begin
            state_q    <= ADDR;
            busy_q     <= 1'b1;
            grant_q    <= win1_d ? 2'b10 : 2'b01;
            write_q    <= win1_d ? write_1 : write_0;
            bus_en_q   <= 1'b1;
            bus_we_q   <= win1_d ? write_1 : write_0;
            bus_addr_q <= win1_d ? address_1 : address_0;
            bus_din_q  <= win1_d ? data_in_1 : data_in_0;
            bus_mask_q <= win1_d ? write_mask_1 : write_mask_0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_q     <= win1_d;
`endif
          end
        end
        ADDR: begin
          state_q  <= WAIT;
          bus_we_q <= 1'b0;
        end
        WAIT: begin
          // Read data is valid on the bus one cycle after the address phase.
          state_q    <= ACK;
          bus_en_q   <= 1'b0;
          bus_addr_q <= '0;
          bus_din_q  <= '0;
          bus_mask_q <= '0;
          ack_q      <= grant_q;
          if (!write_q) begin
            if (grant_q[0]) dout0_q <= bus_data_out;
            else            dout1_q <= bus_data_out;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 2'b00;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_0            = ack_q[0];
  assign ack_1            = ack_q[1];
  assign data_out_0       = dout0_q;
  assign data_out_1       = dout1_q;
  assign bus_address      = bus_addr_q;
  assign bus_data_in      = bus_din_q;
  assign bus_write_mask   = bus_mask_q;
  assign bus_enable       = bus_en_q;
  assign bus_write_enable = bus_we_q;
  assign grant            = grant_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: cycle-accurate phase checks plus a scoreboard of
// expected read-back values popped on each ack.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_0, req_1, write_0, write_1;
  logic [15:0] address_0, address_1;
  logic [31:0] data_in_0, data_in_1;
  logic [3:0]  write_mask_0, write_mask_1;
  logic        ack_0, ack_1;
  logic [31:0] data_out_0, data_out_1;
  logic [15:0] bus_address;
  logic [31:0] bus_data_in;
  logic [3:0]  bus_write_mask;
  logic        bus_enable, bus_write_enable;
  logic [31:0] bus_data_out;
  logic [1:0]  grant;
  logic        busy;

  memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .write_0(write_0), .write_1(write_1),
    .address_0(address_0), .address_1(address_1),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .write_mask_0(write_mask_0), .write_mask_1(write_mask_1),
    .ack_0(ack_0), .ack_1(ack_1), .data_out_0(data_out_0), .data_out_1(data_out_1),
    .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_write_mask(bus_write_mask),
    .bus_enable(bus_enable), .bus_write_enable(bus_write_enable),
    .bus_data_out(bus_data_out), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] dm[2];
  logic        last_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int tie_winner();
`ifdef ARBITER_ROUND_ROBIN_EN
    return last_m ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int who, input logic wr, input logic [15:0] addr,
                       input logic [31:0] din, input logic [3:0] mask);
    if (who == 0) begin
      req_0 = 1'b1; write_0 = wr; address_0 = addr; data_in_0 = din; write_mask_0 = mask;
    end else begin
      req_1 = 1'b1; write_1 = wr; address_1 = addr; data_in_1 = din; write_mask_1 = mask;
    end
  endtask

  // Called in an IDLE cycle with the request already applied; returns in the following IDLE cycle.
  task automatic observe(input int who, input logic wr, input logic [15:0] addr,
                         input logic [31:0] din, input logic [3:0] mask,
                         input logic [31:0] rdata, input logic hold);
    logic [1:0]  oh;
    logic [51:0] bus_exp;
    exp_t        e;
    oh = (who == 0) ? 2'b01 : 2'b10;
    bus_exp = {addr, mask, din};
    if (!wr) dm[who] = rdata;
    sb.push_back('{who: who, data: dm[who]});
    last_m = (who == 1);

    tick();
    chk("addr_ctl", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0},
        {57'd0, 1'b1, wr, 1'b1, oh, 2'b00});
    chk("addr_bus", {12'd0, bus_address, bus_write_mask, bus_data_in}, {12'd0, bus_exp});
    bus_data_out = 32'hBAD0_BAD0;
    if (!hold) begin
      req_0 = 1'b0; req_1 = 1'b0;
      write_0 = ~write_0; write_1 = ~write_1;
      address_0 = ~address_0; address_1 = ~address_1;
      data_in_0 = ~data_in_0; data_in_1 = ~data_in_1;
      write_mask_0 = ~write_mask_0; write_mask_1 = ~write_mask_1;
    end

    tick();
    chk("wait_ctl", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0},
        {57'd0, 1'b1, 1'b0, 1'b1, oh, 2'b00});
    chk("wait_addr", {48'd0, bus_address}, {48'd0, addr});
    bus_data_out = rdata;

    tick();
    bus_data_out = 32'hBAD1_BAD1;
    chk("ack_ctl", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0},
        {57'd0, 1'b0, 1'b0, 1'b1, oh, (who == 1), (who == 0)});
    chk("ack_bus", {12'd0, bus_address, bus_write_mask, bus_data_in}, 64'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("dout_winner", {32'd0, (e.who == 0) ? data_out_0 : data_out_1}, {32'd0, e.data});
      chk("dout_other", {32'd0, (e.who == 0) ? data_out_1 : data_out_0},
          {32'd0, dm[1 - e.who]});
    end

    tick();
    chk("idle_ctl", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_0 = 0; req_1 = 0; write_0 = 0; write_1 = 0;
    address_0 = '0; address_1 = '0; data_in_0 = '0; data_in_1 = '0;
    write_mask_0 = '0; write_mask_1 = '0;
    bus_data_out = 32'hBAD0_BAD0;
    dm[0] = '0; dm[1] = '0; last_m = 1'b1;

    tick(); tick();
    chk("rst_ctl", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0}, 64'd0);
    chk("rst_bus", {12'd0, bus_address, bus_write_mask, bus_data_in}, 64'd0);
    chk("rst_dout", {data_out_1, data_out_0}, 64'd0);
    reset = 1'b0;
    tick();

    drive(0, 1'b0, 16'h0010, 32'h0000_0000, 4'h0);
    observe(0, 1'b0, 16'h0010, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0);

    drive(1, 1'b0, 16'h0020, 32'h0101_0101, 4'h3);
    observe(1, 1'b0, 16'h0020, 32'h0101_0101, 4'h3, 32'hA5A5_0F0F, 1'b0);

    drive(1, 1'b1, 16'hC004, 32'hDEAD_BEEF, 4'hF);
    observe(1, 1'b1, 16'hC004, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 1'b0);

    drive(0, 1'b1, 16'h1234, 32'h0BAD_F00D, 4'h5);
    observe(0, 1'b1, 16'h1234, 32'h0BAD_F00D, 4'h5, 32'h6666_9999, 1'b0);

    // One-cycle request pulse: exactly one transaction, then the arbiter stays idle.
    drive(0, 1'b0, 16'h0044, 32'h0, 4'h0);
    observe(0, 1'b0, 16'h0044, 32'h0, 4'h0, 32'hCAFE_0044, 1'b0);
    tick();
    chk("pulse_idle1", {62'd0, busy, bus_enable}, 64'd0);
    tick();
    chk("pulse_idle2", {61'd0, busy, ack_1, ack_0}, 64'd0);

    // Reset during WAIT aborts the transaction without an ack.
    drive(0, 1'b0, 16'h0040, 32'h0, 4'h0);
    tick();
    req_0 = 1'b0;
    tick();
    chk("rw_wait_ctl", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0},
        {57'd0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00});
    reset = 1'b1;
    bus_data_out = 32'h7777_7777;
    tick();
    dm[0] = '0; dm[1] = '0; last_m = 1'b1;
    chk("rw_ctl", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0}, 64'd0);
    chk("rw_bus", {12'd0, bus_address, bus_write_mask, bus_data_in}, 64'd0);
    chk("rw_dout", {data_out_1, data_out_0}, 64'd0);
    reset = 1'b0;
    tick();
    chk("rw_noack1", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0}, 64'd0);
    tick();
    chk("rw_noack2", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0}, 64'd0);

    // Both requesters held for three transactions.
    drive(0, 1'b0, 16'h0100, 32'h1111_1111, 4'h3);
    drive(1, 1'b0, 16'h0200, 32'h2222_2222, 4'hC);
    for (int k = 0; k < 3; k++) begin
      int w;
      w = tie_winner();
      observe(w, 1'b0, (w == 0) ? 16'h0100 : 16'h0200,
              (w == 0) ? 32'h1111_1111 : 32'h2222_2222, (w == 0) ? 4'h3 : 4'hC,
              32'hC0DE_0000 + 32'(k), 1'b1);
    end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    chk("tie_idle", {57'd0, bus_enable, bus_write_enable, busy, grant, ack_1, ack_0}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
